uart_tx_engine: RTL

Transmit path of the 16550-compatible UART, directly downstream of the register file.
- Accepts bytes pushed by THR writes into a 16-entry FIFO.
- Serializes each byte onto stx_pad_o, framed per LCR, timed by the 16x baud tick (enable) from the divisor logic.
- Returns FIFO fill level and FSM state so the register block can build LSR[5]/LSR[6] and THRE interrupts.

---
 rtl/uart_tx_engine_pkg.sv | 55 +++++
 rtl/uart_tx_engine_fifo.sv | 51 +++++
 rtl/uart_tx_engine.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_tx_engine_pkg.sv
// Shared UART transmit definitions: FIFO sizing, tstate codes, LCR field positions
// and the small framing helpers used by the transmit FSM.
package uart_tx_engine_pkg;

  localparam int unsigned TX_FIFO_DEPTH = 16;
  localparam int unsigned TX_FIFO_CNT_W = 5;
  localparam int unsigned TICK_W        = 5;
  localparam int unsigned BIT_W         = 3;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned LCR_W         = 8;
  localparam int unsigned TICKS_PER_BIT = 16;

  localparam int unsigned LCR_STB = 2;
  localparam int unsigned LCR_PEN = 3;
  localparam int unsigned LCR_EPS = 4;
  localparam int unsigned LCR_SP  = 5;
  localparam int unsigned LCR_BC  = 6;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_POP    = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5
  } tx_state_e;

  // Parity over the active word bits only; stick parity overrides even/odd.
  function automatic logic tx_parity(input logic [DATA_W-1:0] data,
                                     input logic [1:0]        wlen,
                                     input logic              eps,
                                     input logic              sp);
    logic [DATA_W-1:0] mask;
    logic              x;
    unique case (wlen)
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    x = ^(data & mask);
    if (sp) return ~eps;
    if (eps) return x;
    return ~x;
  endfunction

  // Index of the final tick of the stop phase (1, 1.5 or 2 stop bits).
  function automatic logic [TICK_W-1:0] stop_last(input logic       stb,
                                                   input logic [1:0] wlen);
    if (!stb) return TICK_W'(15);
    if (wlen == 2'd0) return TICK_W'(23);
    return TICK_W'(31);
  endfunction

endpackage

// File: rtl/uart_tx_engine_fifo.sv
// Transmit byte FIFO: push, pop, flush and occupancy count; head is read combinationally.
module uart_tx_fifo
  import uart_tx_engine_pkg::*;
#(
  parameter int unsigned DEPTH = TX_FIFO_DEPTH,
  parameter int unsigned CNT_W = TX_FIFO_CNT_W
) (
  input  logic              clk,
  input  logic              wb_rst_i,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_c,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // A full FIFO drops the byte; a flush discards any push in the same cycle.
  assign push_ok = push && !flush && (count != CNT_W'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO plus framing FSM that serializes bytes onto stx_pad_o
// using the 16x baud tick.
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = TX_FIFO_DEPTH,
  parameter int unsigned FIFO_CNT_W = TX_FIFO_CNT_W
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic [LCR_W-1:0]      lcr,
  input  logic                  tf_push,
  input  logic [DATA_W-1:0]     wb_dat_i,
  input  logic                  enable,
  input  logic                  tx_reset,
  output logic                  stx_pad_o,
  output logic [2:0]            tstate,
  output logic [FIFO_CNT_W-1:0] tf_count
);

  tx_state_e          state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_q, par_d;
  logic               stx_d;
  logic               pop_c;
  logic [DATA_W-1:0]  head_c;
  logic               unused_lcr7;

  assign unused_lcr7 = lcr[7];
  assign tstate      = state_q;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FIFO_CNT_W)
  ) u_fifo (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .push     (tf_push),
    .din      (wb_dat_i),
    .pop      (pop_c),
    .flush    (tx_reset),
    .head_c   (head_c),
    .count    (tf_count)
  );

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= TX_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      stx_pad_o <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      stx_pad_o <= stx_d;
    end
  end

  // Next state, counters, shifter and the line level the new state drives.
  always_comb begin
    logic [TICK_W-1:0] phase_last;
    logic [BIT_W-1:0]  bit_last;
    logic              phase_done;
    logic              line;

    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    pop_c      = 1'b0;
    line       = 1'b1;
    bit_last   = BIT_W'(4) + BIT_W'(lcr[1:0]);
    phase_last = (state_q == TX_STOP) ? stop_last(lcr[LCR_STB], lcr[1:0])
                                      : TICK_W'(TICKS_PER_BIT - 1);
    // >= keeps the FSM moving even if lcr shrinks a phase mid-frame.
    phase_done = enable && (tick_q >= phase_last);

    if (enable && (state_q inside {TX_START, TX_DATA, TX_PARITY, TX_STOP}))
      tick_d = phase_done ? '0 : tick_q + TICK_W'(1);

    unique case (state_q)
      TX_IDLE: begin
        if (tf_count != '0) state_d = TX_POP;
      end
      TX_POP: begin
        pop_c   = 1'b1;
        shift_d = head_c;
        par_d   = tx_parity(head_c, lcr[1:0], lcr[LCR_EPS], lcr[LCR_SP]);
        tick_d  = '0;
        bit_d   = '0;
        state_d = TX_START;
      end
      TX_START: begin
        if (phase_done) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (phase_done) begin
          if (bit_q >= bit_last) begin
            bit_d   = '0;
            state_d = lcr[LCR_PEN] ? TX_PARITY : TX_STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
          end
        end
      end
      TX_PARITY: begin
        if (phase_done) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (phase_done) state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase

    unique case (state_d)
      TX_START:  line = 1'b0;
      TX_DATA:   line = shift_d[0];
      TX_PARITY: line = par_d;
      default:   line = 1'b1;
    endcase

    stx_d = lcr[LCR_BC] ? 1'b0 : line;
  end

endmodule
